// File: rtl/xbar_pkg.sv
// rtl/xbar_pkg.sv - shared types and constants for the crossbar toggle handshake
`ifndef QW
`define QW 32
`endif
`ifndef XH
`define XH 4
`endif

package xbar_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    // One crossbar vector: XH lanes of QW bits, lane 0 in the low bits.
    typedef logic [`XH-1:0][`QW-1:0] vec_t;

    localparam int ERR_TIMEOUT   = 0;
    localparam int ERR_UNEXP_ACK = 1;

endpackage

// File: rtl/xbar_issuer_if.sv
// rtl/xbar_issuer_if.sv - upstream, crossbar and status signals of the issuer
`ifndef QW
`define QW 32
`endif
`ifndef XH
`define XH 4
`endif

interface xbar_issuer_if #(
    parameter int CNT_W = 16
);

    xbar_pkg::vec_t     vector_i;
    logic               valid_i;
    logic               ready_o;
    xbar_pkg::vec_t     vector_o;
    logic               valid_o_tg;
    logic               ready_i_tg;
    logic               busy_o;
    logic [CNT_W-1:0]   issued_cnt_o;
    logic [1:0]         err_o;

    // Issuer side.
    modport slave (
        input  vector_i, valid_i, ready_i_tg,
        output ready_o, vector_o, valid_o_tg, busy_o, issued_cnt_o, err_o
    );

    // Feeder / crossbar / observer side.
    modport master (
        output vector_i, valid_i, ready_i_tg,
        input  ready_o, vector_o, valid_o_tg, busy_o, issued_cnt_o, err_o
    );

endinterface

// File: rtl/xbar_issuer_toggle_sync.sv
// rtl/xbar_issuer_toggle_sync.sv - two-flop toggle synchronizer with edge pulse
module toggle_sync (
    input  logic clk,
    input  logic rstn,
    input  logic tg,
    output logic pulse
);

    logic s1;
    logic s2;

    // Bring the foreign toggle into the clk domain; s2 lags s1 by one cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= tg;
            s2 <= s1;
        end
    end

    // Any level change seen between the two stages is one event.
    assign pulse = s1 ^ s2;

endmodule

// File: rtl/xbar_issuer.sv
// rtl/xbar_issuer.sv - transmit side of the crossbar toggle handshake
`ifndef QW
`define QW 32
`endif
`ifndef XH
`define XH 4
`endif

module xbar_issuer
    import xbar_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic          clk,
    input  logic          rstn,
    xbar_issuer_if.slave  bus
);

    localparam int            TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

    logic             ack_pulse;
    logic             xfer;
    state_t           state;
    vec_t             vec_q;
    vec_t             buf_q;
    logic             buf_valid;
    logic             tg_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       err_q;
    logic [TW-1:0]    tmo_q;
    logic [TW-1:0]    tmo_nxt;

    toggle_sync u_ack_sync (
        .clk   (clk),
        .rstn  (rstn),
        .tg    (bus.ready_i_tg),
        .pulse (ack_pulse)
    );

    // The holding buffer is the only thing that can refuse a vector.
    assign xfer = bus.valid_i && !buf_valid;

    // Saturating step of the wait counter; it parks at TIMEOUT.
    always_comb begin
        tmo_nxt = tmo_q;
        if (tmo_q != TMO_MAX) begin
            tmo_nxt = tmo_q + TW'(1);
        end
    end

    // Issue FSM: presents one vector at a time, refills from the buffer or
    // straight from upstream when the acknowledge returns.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            vec_q     <= '0;
            buf_q     <= '0;
            buf_valid <= 1'b0;
            tg_q      <= 1'b0;
            cnt_q     <= '0;
            err_q     <= '0;
            tmo_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ack_pulse) begin
                        err_q[ERR_UNEXP_ACK] <= 1'b1;
                    end
                    if (xfer) begin
                        vec_q <= bus.vector_i;
                        tg_q  <= ~tg_q;
                        tmo_q <= '0;
                        state <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    tmo_q <= tmo_nxt;
                    if ((TIMEOUT != 0) && (tmo_nxt == TMO_MAX)) begin
                        err_q[ERR_TIMEOUT] <= 1'b1;
                    end
                    if (ack_pulse) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (buf_valid) begin
                            vec_q     <= buf_q;
                            tg_q      <= ~tg_q;
                            buf_valid <= 1'b0;
                            tmo_q     <= '0;
                        end else if (xfer) begin
                            // Bypass: the new vector never touches the buffer.
                            vec_q <= bus.vector_i;
                            tg_q  <= ~tg_q;
                            tmo_q <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (xfer) begin
                        buf_q     <= bus.vector_i;
                        buf_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready_o      = !buf_valid;
    assign bus.vector_o     = vec_q;
    assign bus.valid_o_tg   = tg_q;
    assign bus.busy_o       = (state == WAIT_ACK) || buf_valid;
    assign bus.issued_cnt_o = cnt_q;
    assign bus.err_o        = err_q;

endmodule

// File: doc/xbar_issuer.md
Name: xbar_issuer

Overview:
- Transmit side of the crossbar toggle handshake.
- Accepts XH-element input vectors from the upstream feeder (im2col) over a level valid/ready handshake.
- Presents each vector to the crossbar, announces it with one toggle on valid_o_tg, and holds it stable until the crossbar's ready toggle returns.
- Has a one-entry holding buffer so upstream can hand over the next vector while the current one is in flight.
- Also provides a transfer counter and sticky error flags.

Parameters:
- TIMEOUT, 1024: cycles allowed in WAIT_ACK before the timeout error sets; 0 disables the check.
- CNT_W, 16: width of issued_cnt_o.
- Vector geometry uses the shared macros: element width `QW, vector length `XH.

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- vector_i  input  [`QW-1:0] x `XH  upstream vector
- valid_i  input  1  upstream vector valid (level)
- ready_o  output  1  issuer can accept a vector this cycle
- vector_o  output  [`QW-1:0] x `XH  vector driven to the crossbar
- valid_o_tg  output  1  toggles once per issued vector
- ready_i_tg  input  1  crossbar acknowledge toggle (asynchronous to clk)
- busy_o  output  1  a vector is outstanding, or the buffer is occupied
- issued_cnt_o  output  CNT_W  number of acknowledged transfers, wraps
- err_o  output  2  sticky flags: [0] timeout, [1] unexpected acknowledge

Behaviour:
- Reset (async, rstn low):
  - valid_o_tg=0, vector_o all zero, buffer empty, state IDLE.
  - issued_cnt_o=0, err_o=0, ack synchronizer flops =0, timeout counter =0.
  - busy_o=0 and ready_o=1 once rstn is high.
  - A reset mid-transfer discards the outstanding and buffered vectors. No acknowledge is awaited afterwards.
- Ack synchronizer:
  - ready_i_tg passes through two flops, s1 then s2.
  - ack_pulse = s1 ^ s2, which is high for exactly one cycle per toggle.
- Upstream handshake: a transfer occurs when valid_i && ready_o. ready_o = !buf_valid (combinational).
- State IDLE (nothing outstanding):
  - On transfer: next edge loads vector_i into vector_o, inverts valid_o_tg, and moves to WAIT_ACK. Latency is 1 cycle.
  - The buffer is never occupied in IDLE.
- State WAIT_ACK:
  - vector_o and valid_o_tg hold unchanged.
  - A transfer in this state writes vector_i into the buffer (buf_valid=1).
  - On ack_pulse:
    - issued_cnt_o increments (wraps modulo 2^CNT_W).
    - If buf_valid: next edge moves the buffer to vector_o, toggles valid_o_tg, clears buf_valid, and stays in WAIT_ACK.
    - Else if a transfer occurs in the same cycle: vector_i goes directly to vector_o, valid_o_tg toggles, and the state stays in WAIT_ACK (bypass).
    - Else: go to IDLE.
  - With the buffer full, ready_o=0. An ack in that cycle frees the buffer from the next cycle on.
- Timeout:
  - The counter clears on every valid_o_tg toggle and increments each cycle in WAIT_ACK, saturating.
  - When the count equals TIMEOUT (and TIMEOUT != 0), err_o[0] sets.
  - The state machine keeps waiting; a late acknowledge is still accepted normally.
- Unexpected acknowledge: ack_pulse in IDLE sets err_o[1] and is otherwise ignored. The counter does not change.
- Error flags clear only on reset.
- busy_o = (state==WAIT_ACK) || buf_valid.
- The output vector is bit-exact with the accepted input; no arithmetic is performed.
- Minimum turnaround per vector is 1 issue edge + crossbar delay + 2 synchronizer cycles + 1 cycle.

Decomposition:
- Shared package (xbar_pkg):
  - State enum: IDLE, WAIT_ACK.
  - typedef vec_t = logic [`QW-1:0] [`XH].
  - Error bit index constants ERR_TIMEOUT=0, ERR_UNEXP_ACK=1.
- One sub-module, toggle_sync: 2-flop synchronizer plus XOR pulse. The crossbar receiver reuses it for valid_i_tg.

Test Plan:
- Reset then single vector: send vector_i = all 0x3F800000 with valid_i one cycle.
  - Expected: vector_o matches at the next edge, valid_o_tg 0->1, busy_o=1, ready_o stays 1.
  - Crossbar toggles ready_i_tg at t+60 -> IDLE 3 cycles later, issued_cnt_o=1.
- Back-to-back with buffer: present A, then B (0x40000000) while A is outstanding, then C.
  - Expected: ready_o drops after B is accepted.
  - On A's ack: vector_o=B and valid_o_tg toggles back to 0 on the next edge; C is accepted afterwards.
  - issued_cnt_o reaches 3; order A, B, C is preserved.
- Same-cycle bypass: buffer empty, valid_i rises in the exact ack_pulse cycle with vector 0xBF800000.
  - Expected: vector_o updates at the next edge, valid_o_tg toggles, no IDLE visit, buf_valid stays 0.
- Timeout: TIMEOUT=8, issue one vector, never toggle ready_i_tg.
  - Expected: err_o[0]=1 at the 8th WAIT_ACK cycle. A later toggle still returns to IDLE and issued_cnt_o=1.
- Unexpected ack: toggle ready_i_tg while IDLE.
  - Expected: err_o=2'b10, issued_cnt_o unchanged, valid_o_tg unchanged.
- Reset mid-operation: assert rstn low with the buffer full.
  - Expected: all outputs return to reset values immediately. A subsequent stray ack sets err_o[1] only.
